// File: rtl/apu_pulse_source.sv
// apu_pulse_source -- one NES 2A03 pulse (square) channel as a sample source.
//
// Register file ($4000..$4003), 11-bit timer at CPU/2, 8-step duty sequencer,
// envelope generator, length counter and a sample latch that converts the
// 4-bit channel level into a centred signed 16-bit codec sample.
//
// Ports:
//   clk            single clock for all logic
//   reset          synchronous, active-high reset
//   reg_we         one-cycle register write strobe
//   reg_addr       register select 0..3 ($4000..$4003)
//   reg_wdata      register write data
//   enable         channel enable ($4015 bit)
//   cpu_tick       one-cycle pulse at the CPU rate
//   quarter_frame  frame-sequencer quarter tick (envelope clock)
//   half_frame     frame-sequencer half tick (length clock)
//   sample_req     codec request for the next DAC sample
//   audio_output   signed sample, updated the cycle after sample_req
//   channel_level  current channel level 0..15
//   length_active  high while the length counter is nonzero
module apu_pulse_source #(
  parameter int                 SAMPLE_SHIFT  = 11,
  parameter logic signed [15:0] SAMPLE_OFFSET = 16'sd15360
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               reg_we,
  input  logic [1:0]         reg_addr,
  input  logic [7:0]         reg_wdata,
  input  logic               enable,
  input  logic               cpu_tick,
  input  logic               quarter_frame,
  input  logic               half_frame,
  input  logic               sample_req,
  output logic signed [15:0] audio_output,
  output logic [3:0]         channel_level,
  output logic               length_active
);

  logic [7:0]         ctrl_reg;
  logic [7:0]         sweep_unused;   // held for register-map completeness; no sweep unit here
  logic [10:0]        period;
  logic [10:0]        timer;
  logic [2:0]         step;
  logic               phase;
  logic               env_start;
  logic [3:0]         env_decay;
  logic [3:0]         env_div;
  logic [7:0]         length;
  logic signed [15:0] sample_p1;

  logic [1:0] duty;
  logic       halt_loop;
  logic       const_vol;
  logic [3:0] volume;
  logic       wr_len;
  logic [7:0] pattern;
  logic [2:0] bit_idx;

  function automatic logic [7:0] length_lut(input logic [4:0] idx);
    case (idx)
      5'd0:  length_lut = 8'd10;   5'd1:  length_lut = 8'd254;
      5'd2:  length_lut = 8'd20;   5'd3:  length_lut = 8'd2;
      5'd4:  length_lut = 8'd40;   5'd5:  length_lut = 8'd4;
      5'd6:  length_lut = 8'd80;   5'd7:  length_lut = 8'd6;
      5'd8:  length_lut = 8'd160;  5'd9:  length_lut = 8'd8;
      5'd10: length_lut = 8'd60;   5'd11: length_lut = 8'd10;
      5'd12: length_lut = 8'd14;   5'd13: length_lut = 8'd12;
      5'd14: length_lut = 8'd26;   5'd15: length_lut = 8'd14;
      5'd16: length_lut = 8'd12;   5'd17: length_lut = 8'd16;
      5'd18: length_lut = 8'd24;   5'd19: length_lut = 8'd18;
      5'd20: length_lut = 8'd48;   5'd21: length_lut = 8'd20;
      5'd22: length_lut = 8'd96;   5'd23: length_lut = 8'd22;
      5'd24: length_lut = 8'd192;  5'd25: length_lut = 8'd24;
      5'd26: length_lut = 8'd72;   5'd27: length_lut = 8'd26;
      5'd28: length_lut = 8'd16;   5'd29: length_lut = 8'd28;
      5'd30: length_lut = 8'd32;   default: length_lut = 8'd30;
    endcase
  endfunction

  // Patterns are written step 0 first (MSB), so the active bit is [7-step].
  function automatic logic [7:0] duty_pattern(input logic [1:0] d);
    case (d)
      2'd0:    duty_pattern = 8'b0100_0000;
      2'd1:    duty_pattern = 8'b0110_0000;
      2'd2:    duty_pattern = 8'b0111_1000;
      default: duty_pattern = 8'b1001_1111;
    endcase
  endfunction

  function automatic logic signed [15:0] to_sample(input logic [3:0] lvl);
    logic signed [15:0] widened;
    widened   = signed'({12'd0, lvl});
    to_sample = (widened <<< SAMPLE_SHIFT) - SAMPLE_OFFSET;
  endfunction

  assign duty      = ctrl_reg[7:6];
  assign halt_loop = ctrl_reg[5];
  assign const_vol = ctrl_reg[4];
  assign volume    = ctrl_reg[3:0];
  assign wr_len    = reg_we && (reg_addr == 2'd3);
  assign pattern   = duty_pattern(duty);
  assign bit_idx   = 3'd7 - step;

  always_comb begin
    channel_level = 4'd0;
    if ((length != 8'd0) && (period >= 11'd8) && pattern[bit_idx])
      channel_level = const_vol ? volume : env_decay;
  end

  assign length_active = (length != 8'd0);
  assign audio_output  = sample_p1;

  // Register file
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_reg     <= 8'd0;
      sweep_unused <= 8'd0;
      period       <= 11'd0;
    end else if (reg_we) begin
      case (reg_addr)
        2'd0:    ctrl_reg      <= reg_wdata;
        2'd1:    sweep_unused  <= reg_wdata;
        2'd2:    period[7:0]   <= reg_wdata;
        default: period[10:8]  <= reg_wdata[2:0];
      endcase
    end
  end

  // Timer and sequencer: the timer only sees the new period at its next reload
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= 1'b0;
      timer <= 11'd0;
      step  <= 3'd0;
    end else begin
      if (cpu_tick) begin
        phase <= ~phase;
        if (phase) begin
          if (timer == 11'd0) begin
            timer <= period;
            step  <= step + 3'd1;
          end else begin
            timer <= timer - 11'd1;
          end
        end
      end
      if (wr_len)
        step <= 3'd0;
    end
  end

  // Envelope: a $4003 write re-arms the start flag even on a quarter tick
  always_ff @(posedge clk) begin
    if (reset) begin
      env_start <= 1'b0;
      env_decay <= 4'd0;
      env_div   <= 4'd0;
    end else begin
      if (quarter_frame) begin
        if (env_start) begin
          env_start <= 1'b0;
          env_decay <= 4'd15;
          env_div   <= volume;
        end else if (env_div == 4'd0) begin
          env_div <= volume;
          if (env_decay != 4'd0)
            env_decay <= env_decay - 4'd1;
          else if (halt_loop)
            env_decay <= 4'd15;
        end else begin
          env_div <= env_div - 4'd1;
        end
      end
      if (wr_len)
        env_start <= 1'b1;
    end
  end

  // Length counter: priority is disable > load > decrement
  always_ff @(posedge clk) begin
    if (reset) begin
      length <= 8'd0;
    end else if (!enable) begin
      length <= 8'd0;
    end else if (wr_len) begin
      length <= length_lut(reg_wdata[7:3]);
    end else if (half_frame && !halt_loop && (length != 8'd0)) begin
      length <= length - 8'd1;
    end
  end

  // Sample latch: captures the level present in the request cycle
  always_ff @(posedge clk) begin
    if (reset)
      sample_p1 <= to_sample(4'd0);
    else if (sample_req)
      sample_p1 <= to_sample(channel_level);
  end

endmodule
